// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
// The optional checksum trailer is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  // Loader state encoding. CHK is always part of the encoding so that both
  // builds share one type; it is only reachable when the checksum is compiled in.
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loaderState_t;

  // Stream geometry: every multi-byte field is one 32-bit big-endian word.
  localparam int BYTES_PER_WORD = 4;
  localparam int HEADER_BYTES   = 4;

  // Width of the per-word byte counter and the value of the last byte slot.
  localparam int                    BYTE_CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  // Byte address of word idx; 32-bit arithmetic wraps modulo 2^32 by design.
  function automatic logic [31:0] wordAddr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: 8-to-32 big-endian shift register. The first byte of a word
// ends up in bits [31:24]. wordComplete pulses (combinationally) in the cycle
// the 4th byte of a word is accepted; wordNext shows the completed word in that
// same cycle, while word holds it registered from the following cycle onward.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byteIn,
  input  logic        byteAccept,
  output logic [31:0] word,
  output logic [31:0] wordNext,
  output logic        wordComplete
);

  logic [31:0]           wordReg;
  logic [31:0]           shiftNext;
  logic [BYTE_CNT_W-1:0] byteCountReg;

  // Each byte lane takes the lane below it; lane 0 takes the incoming byte.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : gLane
      if (gi == 0) begin : gFirst
        assign shiftNext[7:0] = byteIn;
      end else begin : gShift
        assign shiftNext[8*gi +: 8] = wordReg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  // Shift in a byte on every accepted transfer; counter wraps after 4 bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wordReg      <= '0;
      byteCountReg <= '0;
    end else if (byteAccept) begin
      wordReg      <= shiftNext;
      byteCountReg <= byteCountReg + 1'b1;
    end
  end

  assign word         = wordReg;
  assign wordNext     = shiftNext;
  assign wordComplete = byteAccept && (byteCountReg == LAST_BYTE);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a big-endian program stream (word count N, then N
// words) and writes it into shared memory starting at BASE_ADDR while holding
// the CPU. Defining PROG_LOADER_CHECKSUM_EN adds a 32-bit sum trailer check.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [31:0] memAddr,
  output logic [31:0] memDIn,
  output logic        memWe,
  output logic        cpuHold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  // Where the load goes once the last data word (or an empty header) is seen.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loaderState_t FINAL_STATE = CHK;
`else
  localparam loaderState_t FINAL_STATE = DONE;
`endif

  loaderState_t stateReg, stateNext;
  logic [31:0]  wordCountReg, wordCountNext;
  logic [31:0]  idxReg, idxNext;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]  sumReg, sumNext;
`endif

  logic        byteAccept;
  logic [31:0] asmWord;
  logic [31:0] asmWordNext;
  logic        wordComplete;

  assign byteAccept = byteValid && byteReady;

  // One assembler serves header, data and trailer words alike.
  word_assembler uAssembler (
    .clk          (clk),
    .reset        (reset),
    .byteIn       (byteIn),
    .byteAccept   (byteAccept),
    .word         (asmWord),
    .wordNext     (asmWordNext),
    .wordComplete (wordComplete)
  );

  // State, word count, write index (and running sum) registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg     <= HDR;
      wordCountReg <= '0;
      idxReg       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sumReg       <= '0;
`endif
    end else begin
      stateReg     <= stateNext;
      wordCountReg <= wordCountNext;
      idxReg       <= idxNext;
`ifdef PROG_LOADER_CHECKSUM_EN
      sumReg       <= sumNext;
`endif
    end
  end

  // Next-state logic and Moore-style outputs; the memory bus is zero except in WRITE.
  always_comb begin
    stateNext     = stateReg;
    wordCountNext = wordCountReg;
    idxNext       = idxReg;
`ifdef PROG_LOADER_CHECKSUM_EN
    sumNext       = sumReg;
`endif
    byteReady = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memDIn    = '0;
    cpuHold   = 1'b1;
    done      = 1'b0;
    error     = 1'b0;

    case (stateReg)
      HDR: begin
        // Ready is withheld while reset is asserted so nothing is taken then.
        byteReady = !reset;
        if (wordComplete) begin
          wordCountNext = asmWordNext;
          if (asmWordNext == '0) begin
            stateNext = FINAL_STATE;
          end else if (asmWordNext > MAX_WORDS_W) begin
            stateNext = ERR;
          end else begin
            stateNext = DATA;
          end
        end
      end

      DATA: begin
        byteReady = !reset;
        if (wordComplete) begin
          stateNext = WRITE;
        end
      end

      WRITE: begin
        // Single-cycle strobe; the assembled word is already registered here.
        memWe   = 1'b1;
        memAddr = wordAddr(BASE_ADDR, idxReg);
        memDIn  = asmWord;
        idxNext = idxReg + 32'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        sumNext = sumReg + asmWord;
`endif
        if (idxReg == wordCountReg - 32'd1) begin
          stateNext = FINAL_STATE;
        end else begin
          stateNext = DATA;
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        // Trailer word is compared as it completes, against the sum of all writes.
        byteReady = !reset;
        if (wordComplete) begin
          if (asmWordNext == sumReg) begin
            stateNext = DONE;
          end else begin
            stateNext = ERR;
          end
        end
      end
`endif

      DONE: begin
        cpuHold = 1'b0;
        done    = 1'b1;
      end

      ERR: begin
        error = 1'b1;
      end

      default: begin
        // Unreachable encodings park in the error state rather than writing.
        stateNext = ERR;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader. Expected
// writes and outcomes come from a list-level model of the stream.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 4;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [31:0] memAddr;
  logic [31:0] memDIn;
  logic        memWe;
  logic        cpuHold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  logic [31:0] stimWords[$];

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .memAddr   (memAddr),
    .memDIn    (memDIn),
    .memWe     (memWe),
    .cpuHold   (cpuHold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor: logs each write, checks the bus is quiet otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (memWe) begin
        wrAddrQ.push_back(memAddr);
        wrDataQ.push_back(memDIn);
        $display("write addr=%08h data=%08h", memAddr, memDIn);
      end else begin
        vectors++;
        if (memAddr !== 32'h0 || memDIn !== 32'h0) begin
          $display("FAIL idle_bus addr=%08h data=%08h want 0/0", memAddr, memDIn);
          miscompares++;
        end
      end
    end
  end

  // Reference: sum of all data words modulo 2^32.
  function automatic logic [31:0] modelSum();
    logic [31:0] s = 32'h0;
    foreach (stimWords[i]) s += stimWords[i];
    return s;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    byteValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  // Offer one byte after 0..gapMax idle cycles and hold it until accepted.
  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int waitCyc;
    if (gapMax > 0) begin
      repeat ($urandom_range(0, gapMax)) begin
        @(negedge clk);
        byteIn = 8'($urandom);
      end
    end
    @(negedge clk);
    byteIn = b;
    byteValid = 1'b1;
    waitCyc = 0;
    while (!byteReady && waitCyc < 100) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!byteReady) begin
      vectors++;
      $display("FAIL byte_accept_timeout byteReady=%b want 1", byteReady);
      miscompares++;
      byteValid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      lastAcceptCyc = cyc;
      byteValid = 1'b0;
      byteIn = 8'($urandom);
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapMax);
    for (int i = 3; i >= 0; i--) sendByte(w[8*i +: 8], gapMax);
  endtask

  task automatic waitFinish(output int finCyc);
    int w = 0;
    while (!(done || error) && w < 100) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (!(done || error)) begin
      $display("FAIL finish_timeout done=%b error=%b want one set", done, error);
      miscompares++;
    end
    finCyc = cyc;
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    vectors += 7;
    if (byteReady !== 1'b1) begin $display("FAIL reset_byteReady got %b want 1", byteReady); miscompares++; end
    if (memWe !== 1'b0)     begin $display("FAIL reset_memWe got %b want 0", memWe); miscompares++; end
    if (memAddr !== 32'h0)  begin $display("FAIL reset_memAddr got %08h want 0", memAddr); miscompares++; end
    if (memDIn !== 32'h0)   begin $display("FAIL reset_memDIn got %08h want 0", memDIn); miscompares++; end
    if (cpuHold !== 1'b1)   begin $display("FAIL reset_cpuHold got %b want 1", cpuHold); miscompares++; end
    if (done !== 1'b0)      begin $display("FAIL reset_done got %b want 0", done); miscompares++; end
    if (error !== 1'b0)     begin $display("FAIL reset_error got %b want 0", error); miscompares++; end
  endtask

  task automatic test_example();
    int fin;
    doReset();
    stimWords = '{32'h2008_0005, 32'h8C09_0004};
    sendWord(32'd2, 1);
    foreach (stimWords[i]) sendWord(stimWords[i], 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    sendWord(32'hAC11_0009, 1);
`endif
    waitFinish(fin);
    vectors += 4;
    if (wrAddrQ.size() !== 2) begin
      $display("FAIL example_count got %0d want 2", wrAddrQ.size()); miscompares++;
    end else begin
      vectors += 4;
      if (wrAddrQ[0] !== 32'h0) begin $display("FAIL example_addr0 got %08h want 00000000", wrAddrQ[0]); miscompares++; end
      if (wrDataQ[0] !== 32'h2008_0005) begin $display("FAIL example_data0 got %08h want 20080005", wrDataQ[0]); miscompares++; end
      if (wrAddrQ[1] !== 32'h4) begin $display("FAIL example_addr1 got %08h want 00000004", wrAddrQ[1]); miscompares++; end
      if (wrDataQ[1] !== 32'h8C09_0004) begin $display("FAIL example_data1 got %08h want 8C090004", wrDataQ[1]); miscompares++; end
    end
    if (done !== 1'b1)      begin $display("FAIL example_done got %b want 1", done); miscompares++; end
    if (cpuHold !== 1'b0)   begin $display("FAIL example_cpuHold got %b want 0", cpuHold); miscompares++; end
    if (error !== 1'b0)     begin $display("FAIL example_error got %b want 0", error); miscompares++; end
    if (byteReady !== 1'b0) begin $display("FAIL example_byteReady got %b want 0", byteReady); miscompares++; end
  endtask

  task automatic test_zero_words();
    int fin;
    doReset();
    stimWords.delete();
    sendWord(32'd0, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
    sendWord(32'd0, 2);
`endif
    waitFinish(fin);
    repeat (4) @(negedge clk);
    vectors += 3;
    if (wrAddrQ.size() !== 0) begin $display("FAIL zero_writes got %0d want 0", wrAddrQ.size()); miscompares++; end
    if (done !== 1'b1)        begin $display("FAIL zero_done got %b want 1", done); miscompares++; end
    if (cpuHold !== 1'b0)     begin $display("FAIL zero_cpuHold got %b want 0", cpuHold); miscompares++; end
  endtask

  task automatic test_overflow();
    int fin;
    doReset();
    sendWord(32'(MAXW + 1), 2);
    waitFinish(fin);
    // Keep offering bytes: none may be taken and nothing may be written.
    byteValid = 1'b1;
    byteIn = 8'hA5;
    repeat (6) @(negedge clk);
    vectors += 5;
    if (error !== 1'b1)       begin $display("FAIL ovf_error got %b want 1", error); miscompares++; end
    if (cpuHold !== 1'b1)     begin $display("FAIL ovf_cpuHold got %b want 1", cpuHold); miscompares++; end
    if (byteReady !== 1'b0)   begin $display("FAIL ovf_byteReady got %b want 0", byteReady); miscompares++; end
    if (done !== 1'b0)        begin $display("FAIL ovf_done got %b want 0", done); miscompares++; end
    if (wrAddrQ.size() !== 0) begin $display("FAIL ovf_writes got %0d want 0", wrAddrQ.size()); miscompares++; end
    byteValid = 1'b0;
  endtask

  task automatic test_random_loads();
    int fin;
    int n;
    for (int r = 0; r < 6; r++) begin
      doReset();
      n = $urandom_range(1, 12);
      stimWords.delete();
      for (int i = 0; i < n; i++) stimWords.push_back($urandom);
      sendWord(32'(n), 3);
      foreach (stimWords[i]) sendWord(stimWords[i], 3);
`ifdef PROG_LOADER_CHECKSUM_EN
      sendWord(modelSum(), 3);
`endif
      waitFinish(fin);
      vectors += 3;
      if (done !== 1'b1)  begin $display("FAIL rand_done run=%0d got %b want 1", r, done); miscompares++; end
      if (error !== 1'b0) begin $display("FAIL rand_error run=%0d got %b want 0", r, error); miscompares++; end
      if (wrAddrQ.size() !== n) begin
        $display("FAIL rand_count run=%0d got %0d want %0d", r, wrAddrQ.size(), n); miscompares++;
      end else begin
        for (int i = 0; i < n; i++) begin
          vectors++;
          if (wrAddrQ[i] !== BASE + 32'(i) * 32'd4 || wrDataQ[i] !== stimWords[i]) begin
            $display("FAIL rand_write run=%0d i=%0d got %08h@%08h want %08h@%08h",
                     r, i, wrDataQ[i], wrAddrQ[i], stimWords[i], BASE + 32'(i) * 32'd4);
            miscompares++;
          end
        end
      end
    end
  endtask

  task automatic test_valid_toggle();
    int fin;
    doReset();
    stimWords = '{32'h1234_5678};
    sendWord(32'd1, 5);
    sendWord(32'h1234_5678, 5);
`ifdef PROG_LOADER_CHECKSUM_EN
    sendWord(32'h1234_5678, 5);
`endif
    waitFinish(fin);
    vectors += 2;
    if (done !== 1'b1) begin $display("FAIL toggle_done got %b want 1", done); miscompares++; end
    if (wrAddrQ.size() !== 1) begin
      $display("FAIL toggle_count got %0d want 1", wrAddrQ.size()); miscompares++;
    end else begin
      vectors++;
      if (wrAddrQ[0] !== BASE || wrDataQ[0] !== 32'h1234_5678) begin
        $display("FAIL toggle_write got %08h@%08h want 12345678@%08h", wrDataQ[0], wrAddrQ[0], BASE);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_midload();
    int fin;
    logic [31:0] w;
    doReset();
    sendWord(32'd2, 1);
    sendByte(8'hDE, 1);
    sendByte(8'hAD, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (memWe !== 1'b0) begin $display("FAIL midrst_memWe got %b want 0", memWe); miscompares++; end
    end
    vectors++;
    if (wrAddrQ.size() !== 0) begin $display("FAIL midrst_writes got %0d want 0", wrAddrQ.size()); miscompares++; end
    reset = 1'b0;
    wrAddrQ.delete();
    wrDataQ.delete();
    w = $urandom;
    stimWords = '{w};
    sendWord(32'd1, 2);
    sendWord(w, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
    sendWord(modelSum(), 2);
`endif
    waitFinish(fin);
    vectors += 2;
    if (done !== 1'b1) begin $display("FAIL midrst_done got %b want 1", done); miscompares++; end
    if (wrAddrQ.size() !== 1) begin
      $display("FAIL midrst_count got %0d want 1", wrAddrQ.size()); miscompares++;
    end else begin
      vectors++;
      if (wrAddrQ[0] !== BASE || wrDataQ[0] !== w) begin
        $display("FAIL midrst_write got %08h@%08h want %08h@%08h", wrDataQ[0], wrAddrQ[0], w, BASE);
        miscompares++;
      end
    end
  endtask

  // Full MAX_WORDS load with no source gaps: 5 cycles per word.
  task automatic test_back_to_back();
    int fin;
    int k0;
    int bad;
    doReset();
    stimWords.delete();
    for (int i = 0; i < MAXW; i++) stimWords.push_back($urandom);
    sendByte(8'(MAXW >> 24), 0);
    k0 = lastAcceptCyc;
    sendByte(8'(MAXW >> 16), 0);
    sendByte(8'(MAXW >> 8), 0);
    sendByte(8'(MAXW), 0);
    foreach (stimWords[i]) sendWord(stimWords[i], 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    sendWord(modelSum(), 0);
`endif
    waitFinish(fin);
    vectors += 3;
    if (fin - k0 !== 3 + 5 * MAXW + CHK_EXTRA) begin
      $display("FAIL b2b_cycles got %0d want %0d", fin - k0, 3 + 5 * MAXW + CHK_EXTRA); miscompares++;
    end
    if (done !== 1'b1) begin $display("FAIL b2b_done got %b want 1", done); miscompares++; end
    if (wrAddrQ.size() !== MAXW) begin
      $display("FAIL b2b_count got %0d want %0d", wrAddrQ.size(), MAXW); miscompares++;
    end else begin
      bad = 0;
      for (int i = 0; i < MAXW; i++) begin
        vectors++;
        if (wrAddrQ[i] !== BASE + 32'(i) * 32'd4 || wrDataQ[i] !== stimWords[i]) begin
          if (bad < 4)
            $display("FAIL b2b_write i=%0d got %08h@%08h want %08h@%08h",
                     i, wrDataQ[i], wrAddrQ[i], stimWords[i], BASE + 32'(i) * 32'd4);
          bad++;
          miscompares++;
        end
      end
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int fin;
    doReset();
    sendWord(32'd1, 1);
    sendWord(32'h0000_0001, 1);
    sendWord(32'h0000_0002, 1);
    waitFinish(fin);
    vectors += 4;
    if (error !== 1'b1)   begin $display("FAIL badsum_error got %b want 1", error); miscompares++; end
    if (done !== 1'b0)    begin $display("FAIL badsum_done got %b want 0", done); miscompares++; end
    if (cpuHold !== 1'b1) begin $display("FAIL badsum_cpuHold got %b want 1", cpuHold); miscompares++; end
    if (wrAddrQ.size() !== 1) begin
      $display("FAIL badsum_count got %0d want 1", wrAddrQ.size()); miscompares++;
    end else begin
      vectors++;
      if (wrAddrQ[0] !== BASE || wrDataQ[0] !== 32'h1) begin
        $display("FAIL badsum_write got %08h@%08h want 00000001@%08h", wrDataQ[0], wrAddrQ[0], BASE);
        miscompares++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_example();
    test_zero_words();
    test_overflow();
    test_random_loads();
    test_valid_toggle();
    test_reset_midload();
    test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of first loaded word.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word count.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 byteIn  input  8  incoming program stream byte.
REQ-006 byteValid  input  1  byteIn valid this cycle.
REQ-007 byteReady  output  1  loader accepts byteIn this cycle; transfer occurs when byteValid and byteReady both high at rising edge.
REQ-008 memAddr  output  32  word-aligned byte write address into shared instruction/data memory.
REQ-009 memDIn  output  32  write data.
REQ-010 memWe  output  1  single-cycle write strobe, memory samples on rising edge.
REQ-011 cpuHold  output  1  holds CPU PC at 0 and blocks CPU writes while high.
REQ-012 done  output  1  load finished successfully.
REQ-013 error  output  1  load aborted.

Function
REQ-014 Stream format SHALL be: 4-byte word count N, then N words; all multi-byte fields big-endian, most significant byte first.
REQ-015 States SHALL be HDR, DATA, WRITE, CHK, DONE, ERR.
REQ-016 HDR: byteReady=1; after 4th accepted byte, N latched; N=0 -> CHK when checksum is compiled in, else DONE; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-017 DATA: byteReady=1; bytes shift into a 32-bit assembly register; 4th accepted byte -> WRITE on next edge.
REQ-018 WRITE: exactly one cycle; byteReady=0, memWe=1, memAddr=BASE_ADDR+4*idx, memDIn=assembled word; idx increments; idx==N-1 -> CHK or DONE, else -> DATA.
REQ-019 memAddr arithmetic SHALL be 32-bit modulo 2^32; wrap is not an error.
REQ-020 memWe SHALL be 0 in every state except WRITE; memAddr/memDIn SHALL be 0 outside WRITE.
REQ-021 Bytes presented while byteReady=0 SHALL NOT be consumed; the source holds byteIn/byteValid until accepted.
REQ-022 Minimum throughput SHALL be one word per 5 cycles (4 accept + 1 write).
REQ-023 DONE: byteReady=0, cpuHold=0, done=1; sticky until reset.
REQ-024 ERR: byteReady=0, cpuHold=1, error=1, no further writes; sticky until reset.
REQ-025 cpuHold SHALL be 1 in every state except DONE.

Reset
REQ-026 reset high SHALL immediately force HDR, clear byte counter, idx, N, assembly register and checksum; outputs byteReady=1 (once reset deasserts), memWe=0, memAddr=0, memDIn=0, cpuHold=1, done=0, error=0.
REQ-027 Reset mid-load SHALL abandon the partial word without writing it; memory contents already written are left unchanged.

Configuration
REQ-028 With PROG_LOADER_CHECKSUM_EN defined: a running 32-bit modulo-2^32 sum of all data words is kept; CHK accepts 4 further bytes and compares them to the sum; match -> DONE, mismatch -> ERR.
REQ-029 Without PROG_LOADER_CHECKSUM_EN: CHK state, sum register and trailer bytes are absent; the last WRITE goes directly to DONE.

Structure
REQ-030 Package prog_loader_pkg SHALL hold the state encoding, BYTES_PER_WORD=4 and the header length constant.
REQ-031 One sub-module, word_assembler (8-to-32 big-endian shift register with 2-bit byte counter and word-complete pulse), SHALL be used for both header and data/checksum assembly.

Verification
REQ-032 Stream 00 00 00 02, 20 08 00 05, 8C 09 00 04 (plus trailer AC 11 00 09 when checksum is compiled in) -> writes 20080005 @0x0, 8C090004 @0x4, then done=1, cpuHold=0.
REQ-033 Header 00 00 00 00 -> no memWe; done=1 (checksum build requires trailer 00 00 00 00 first).
REQ-034 Header N=MAX_WORDS+1 (00 00 04 01) -> error=1, cpuHold=1, byteReady=0, no memWe ever.
REQ-035 byteValid toggled at random, one word 12 34 56 78 -> exactly one write 12345678 @BASE_ADDR; no byte lost or duplicated.
REQ-036 reset asserted after 2 bytes of word 1 -> no memWe for that word; a fresh stream after reset loads correctly from BASE_ADDR.
REQ-037 Checksum build, one word 00 00 00 01 with trailer 00 00 00 02 -> error=1 after the write of 00000001 @BASE_ADDR.
